// File: rtl/carry_save_adder_pkg.sv
// rtl/carry_save_adder_pkg.sv - shared widths and latency constants for the four-operand carry-save adder
package carry_save_adder_pkg;

  // Operand width used when the top is instantiated without an override
  localparam int DEFAULT_WIDTH = 4;

  // Exact result width for four operands of DEFAULT_WIDTH bits
  localparam int RES_W = DEFAULT_WIDTH + 2;

  // Result latency in cycles without / with the CSA-to-CPA pipeline register
  localparam int LAT_NOPIPE = 1;
  localparam int LAT_PIPE   = 2;

  // Result width for an arbitrary operand width: four operands add two bits of growth
  function automatic int res_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/carry_save_adder_4op_csa.sv
// rtl/carry_save_adder_4op_csa.sv - one 3:2 compressor row (bitwise full adders, no carry ripple)
module csa_3to2
  import carry_save_adder_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] z_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  // Each bit position is an independent full adder; carry_o[i] carries weight 2^(i+1)
  always_comb begin
    sum_o   = x_i ^ y_i ^ z_i;
    carry_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  end

endmodule

// File: rtl/carry_save_adder_4op.sv
// rtl/carry_save_adder_4op.sv - four-operand unsigned adder: two CSA rows, ripple CPA, registered result
// Optional macro CARRY_SAVE_ADDER_PIPE_EN registers the CSA tree output before the CPA (latency 2 instead of 1).
module carry_save_adder_4op
  import carry_save_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int RW = res_width(WIDTH);

  // Stage 1 works at operand width; stage 2 needs one extra bit because k1 is shifted left
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] k1;
  logic [WIDTH:0]   s2;
  logic [WIDTH:0]   k2;

  // CPA operands and the valid bit that travels with them
  logic [RW-1:0]    cpa_x;
  logic [RW-1:0]    cpa_y;
  logic             cpa_valid;
  logic [RW-1:0]    total_d;

  // Result registers
  logic [WIDTH:0]   sum_q;
  logic             cout_q;
  logic             out_valid_q;

  csa_3to2 #(
    .N (WIDTH)
  ) u_csa_stage1 (
    .x_i     (a),
    .y_i     (b),
    .z_i     (c),
    .sum_o   (s1),
    .carry_o (k1)
  );

  csa_3to2 #(
    .N (WIDTH + 1)
  ) u_csa_stage2 (
    .x_i     ({1'b0, s1}),
    .y_i     ({k1, 1'b0}),
    .z_i     ({1'b0, d}),
    .sum_o   (s2),
    .carry_o (k2)
  );

`ifdef CARRY_SAVE_ADDER_PIPE_EN
  logic [WIDTH:0] s2_q;
  logic [WIDTH:0] k2_q;
  logic           pipe_valid_q;

  // Hold the redundant (sum, carry) pair for one cycle so the CPA gets a full cycle of its own
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q         <= '0;
      k2_q         <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      pipe_valid_q <= in_valid;
      if (in_valid) begin
        s2_q <= s2;
        k2_q <= k2;
      end
    end
  end

  assign cpa_x     = {1'b0, s2_q};
  assign cpa_y     = {k2_q, 1'b0};
  assign cpa_valid = pipe_valid_q;
`else
  assign cpa_x     = {1'b0, s2};
  assign cpa_y     = {k2, 1'b0};
  assign cpa_valid = in_valid;
`endif

  // Carry-propagate adder: the only place a carry crosses bit positions
  always_comb begin
    logic carry;
    carry   = 1'b0;
    total_d = '0;
    for (int i = 0; i < RW; i++) begin
      total_d[i] = cpa_x[i] ^ cpa_y[i] ^ carry;
      carry      = (cpa_x[i] & cpa_y[i]) | (carry & (cpa_x[i] ^ cpa_y[i]));
    end
  end

  // Capture a qualified total; idle cycles keep the last result and drop out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= cpa_valid;
      if (cpa_valid) begin
        sum_q  <= total_d[WIDTH:0];
        cout_q <= total_d[WIDTH+1];
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_save_adder_4op.sv
// tb/tb_carry_save_adder_4op.sv - directed and random checks of carry_save_adder_4op against an arithmetic model
module tb_carry_save_adder_4op;
  import carry_save_adder_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef CARRY_SAVE_ADDER_PIPE_EN
  localparam int LAT = LAT_PIPE;
`else
  localparam int LAT = LAT_NOPIPE;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W:0]   sum;
  logic         cout;
  logic         out_valid;

  int vectors;
  int miscompares;

  // Expected totals of operand sets in flight, oldest first
  int unsigned exp_q[$];

  // Directed table: a, b, c, d, expected sum, expected cout
  int unsigned tbl [7][6] = '{
    '{10,  0,  0,  0, 10, 0},
    '{ 4,  6, 12,  0, 22, 0},
    '{11,  2,  4,  7, 24, 0},
    '{12,  5, 10, 10,  5, 1},
    '{ 7,  6, 12,  8,  1, 1},
    '{15, 15, 15, 15, 28, 1},
    '{20,  0, 20,  0,  8, 0}
  };

  carry_save_adder_4op #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operands truncated to the port width, then added as plain integers
  function automatic int unsigned model_total(input int unsigned x, input int unsigned y,
                                              input int unsigned z, input int unsigned w);
    int unsigned m;
    m = (32'd1 << W) - 1;
    return (x & m) + (y & m) + (z & m) + (w & m);
  endfunction

  function automatic int unsigned model_sum(input int unsigned t);
    return t % (32'd1 << (RES_W - 1));
  endfunction

  function automatic int unsigned model_cout(input int unsigned t);
    return (t >> (RES_W - 1)) & 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int unsigned x, input int unsigned y, input int unsigned z,
                       input int unsigned w, input logic v);
    a        = W'(x);
    b        = W'(y);
    c        = W'(z);
    d        = W'(w);
    in_valid = v;
  endtask

  // Present one operand set for one cycle, then check it after the configured latency
  task automatic one_shot(input int unsigned x, input int unsigned y, input int unsigned z,
                          input int unsigned w, input int unsigned exp_s, input int unsigned exp_c,
                          input string tag);
    drive(x, y, z, w, 1'b1);
    @(posedge clk);
    #1;
    drive($urandom, $urandom, $urandom, $urandom, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
    end
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"}, {{(31 - W){1'b0}}, sum}, exp_s);
    check({tag, ".cout"}, {31'd0, cout}, exp_c);
    @(posedge clk);
    #1;
    check({tag, ".idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int unsigned t;
    int unsigned ra, rb, rc, rd;
    int unsigned last_t;
    int idx;
    vectors     = 0;
    miscompares = 0;
    last_t      = 0;

    // Reset held with live random operands: outputs stay cleared
    rst_n = 1'b0;
    drive($urandom, $urandom, $urandom, $urandom, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("rst.sum", {{(31 - W){1'b0}}, sum}, 32'd0);
      check("rst.cout", {31'd0, cout}, 32'd0);
      check("rst.valid", {31'd0, out_valid}, 32'd0);
      drive($urandom, $urandom, $urandom, $urandom, 1'b1);
    end
    drive(0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases with constants worked out by hand
    for (int i = 0; i < 7; i++)
      one_shot(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4], tbl[i][5],
               $sformatf("dir%0d", i));

    // Random single operand sets against the model
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      t  = model_total(ra, rb, rc, rd);
      one_shot(ra, rb, rc, rd, model_sum(t), model_cout(t), $sformatf("rnd%0d", i));
    end

    // Streaming: 8 back-to-back operand sets, then one idle cycle
    for (int e = 0; e < 8 + LAT; e++) begin
      if (e < 8) begin
        ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
        drive(ra, rb, rc, rd, 1'b1);
        exp_q.push_back(model_total(ra, rb, rc, rd));
      end else begin
        drive($urandom, $urandom, $urandom, $urandom, 1'b0);
      end
      @(posedge clk);
      #1;
      idx = e - (LAT - 1);
      if (idx >= 0 && idx < 8) begin
        t      = exp_q.pop_front();
        last_t = t;
        check($sformatf("strm%0d.valid", idx), {31'd0, out_valid}, 32'd1);
        check($sformatf("strm%0d.sum", idx), {{(31 - W){1'b0}}, sum}, model_sum(t));
        check($sformatf("strm%0d.cout", idx), {31'd0, cout}, model_cout(t));
      end else if (idx >= 8) begin
        check("strm.gap.valid", {31'd0, out_valid}, 32'd0);
        check("strm.gap.hold", {{(31 - W){1'b0}}, sum}, model_sum(last_t));
      end else begin
        check("strm.fill.valid", {31'd0, out_valid}, 32'd0);
      end
    end

    // Mid-stream asynchronous reset between clock edges
    for (int e = 0; e < 3; e++) begin
      drive($urandom, $urandom, $urandom, $urandom, 1'b1);
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.sum", {{(31 - W){1'b0}}, sum}, 32'd0);
    check("arst.cout", {31'd0, cout}, 32'd0);
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      check("arst.nostale", {31'd0, out_valid}, 32'd0);
    end

    // First result after reset release arrives at the configured latency
    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    t  = model_total(ra, rb, rc, rd);
    one_shot(ra, rb, rc, rd, model_sum(t), model_cout(t), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/carry_save_adder_4op.md
# carry_save_adder_4op

Four-operand unsigned adder built from a carry-save (3:2 compressor) tree followed by one carry-propagate adder. It reduces four WIDTH-bit operands to an exact WIDTH+2-bit total. That total is presented as a WIDTH+1-bit `sum` plus a separate `cout` MSB. It sits in datapaths needing multi-operand accumulation (checksums, dot-product partial sums) and registers its result behind a valid flag.

## Interface
- WIDTH, default 4: bit width of each operand; minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  operands on a/b/c/d are valid this cycle.
- a  input  WIDTH  operand 0, unsigned.
- b  input  WIDTH  operand 1, unsigned.
- c  input  WIDTH  operand 2, unsigned.
- d  input  WIDTH  operand 3, unsigned.
- sum  output  WIDTH+1  low WIDTH+1 bits of a+b+c+d.
- cout  output  1  bit WIDTH+1 of a+b+c+d (total MSB).
- out_valid  output  1  sum/cout hold a new result.
- Module name is carry_save_adder_4op.

## Operation
- Total definition: {cout, sum} = a + b + c + d, computed exactly with no overflow.
  - Maximum total is 4·(2^WIDTH−1), which always fits in WIDTH+2 bits.
- Operands are WIDTH bits. Wider stimulus values are truncated by the port width; e.g. 20 on a 4-bit port is 4.
- CSA stage 1: a, b, c → partial sum s1 and carry k1 (k1 weighted ×2).
- CSA stage 2: s1, k1<<1, d → partial sum s2 and carry k2.
- Final CPA: s2 + (k2<<1), computed at WIDTH+2 bits.
- No carry may propagate across bit positions inside the CSA stages; only the CPA ripples.
- Arithmetic is unsigned only; there is no saturation and no sign handling.
- in_valid is a pure qualifier:
  - When in_valid=0, the result registers hold their values and out_valid deasserts the cycle after.
- There is no backpressure; the block accepts a new operand set every cycle.

## Timing
- Reset (rst_n=0, asynchronous): sum=0, cout=0, out_valid=0. Any pipeline registers also clear.
- Without CSA_PIPE_EN, latency is 1 cycle:
  - Operands sampled at edge N with in_valid=1 appear on sum/cout with out_valid=1 after edge N.
- With CSA_PIPE_EN, latency is 2 cycles. Throughput stays 1 result per cycle in both configurations.
- Back-to-back valid inputs produce back-to-back valid outputs in order.
- Reset asserted mid-operation discards all in-flight results. The first out_valid after release follows the first post-reset in_valid by the configured latency.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CARRY_SAVE_ADDER_PIPE_EN defined:
  - Registers s2/k2 and their valid bit between the CSA tree and the CPA.
  - Latency is 2.
- CARRY_SAVE_ADDER_PIPE_EN undefined:
  - CSA tree and CPA are one combinational path into the output register.
  - Latency is 1.

## Structure
- Shared package carry_save_adder_pkg holds:
  - Default WIDTH constant.
  - Derived result width RES_W = WIDTH+2.
  - Latency constants LAT_NOPIPE=1 and LAT_PIPE=2.
- One sub-module, csa_3to2:
  - WIDTH-parameterized row of full adders, outputting a bitwise sum vector and a carry vector.
  - Instantiated twice (stages 1 and 2).
- The CPA is written inline in the top module.

## Test plan
- Reset: hold rst_n=0 with random inputs → sum=0, cout=0, out_valid=0; release, drive a=10, others 0 → sum=10, cout=0 after configured latency.
- Carry chain: a=4, b=6, c=12, d=0 → sum=22, cout=0; a=11, b=2, c=4, d=7 → sum=24, cout=0.
- Overflow into cout:
  - a=12, b=5, c=10, d=10 → sum=5, cout=1 (total 37).
  - a=7, b=6, c=12, d=8 → sum=1, cout=1 (total 33).
- Maximum: a=b=c=d=15 → sum=28, cout=1 (total 60); truncated input a=20, c=20 (4-bit ports) → sum=8, cout=0.
- Streaming: 8 consecutive in_valid cycles of random operands → 8 consecutive out_valid results, in order, each matching the reference sum; then one in_valid=0 gap → out_valid=0 for one cycle.
- Mid-stream reset: assert rst_n=0 asynchronously between edges during streaming → outputs clear immediately, no stale result emerges after release.
